// File: rtl/csa_acc_pkg.sv
// Shared types, widths and the operand extension helper for the carry-save accumulator.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int STALL_CNT_W = 16;
    localparam int EXT_MAX_W   = 64;

    // Extends the low in_w bits of data to EXT_MAX_W bits; callers keep the low bits they need.
    function automatic logic [EXT_MAX_W-1:0] ext_operand(
        input logic [EXT_MAX_W-1:0] data,
        input int                   in_w,
        input logic                 is_signed
    );
        logic [EXT_MAX_W-1:0] keep;
        logic                 fill;
        keep = ~({EXT_MAX_W{1'b1}} << in_w);
        fill = is_signed & (|(data & ({{(EXT_MAX_W-1){1'b0}}, 1'b1} << (in_w - 1))));
        return (data & keep) | (fill ? ~keep : '0);
    endfunction

endpackage

// File: rtl/compressor_4_2_n_bit.sv
// Bit-parallel 4:2 compressor built from two chained 3:2 rows; sum + carry equals in0+in1+in2+in3.
module compressor_4_2_n_bit #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 17,
    parameter int SHIFT_CARRY  = 1
) (
    input  logic [INPUT_WIDTH-1:0]  in0,
    input  logic [INPUT_WIDTH-1:0]  in1,
    input  logic [INPUT_WIDTH-1:0]  in2,
    input  logic [INPUT_WIDTH-1:0]  in3,
    output logic [OUTPUT_WIDTH-1:0] sum,
    output logic [OUTPUT_WIDTH-1:0] carry
);

    logic [INPUT_WIDTH-1:0] s1;
    logic [INPUT_WIDTH-1:0] co1;
    logic [INPUT_WIDTH-1:0] cin;
    logic [INPUT_WIDTH-1:0] s2;
    logic [INPUT_WIDTH-1:0] c2;
    logic [INPUT_WIDTH:0]   sum_full;
    logic [INPUT_WIDTH:0]   carry_full;

    assign s1  = in0 ^ in1 ^ in2;
    assign co1 = (in0 & in1) | (in0 & in2) | (in1 & in2);
    // First-row carries ripple one position into the second row; the top one becomes the sum MSB.
    assign cin = {co1[INPUT_WIDTH-2:0], 1'b0};
    assign s2  = s1 ^ in3 ^ cin;
    assign c2  = (s1 & in3) | (s1 & cin) | (in3 & cin);

    assign sum_full = {co1[INPUT_WIDTH-1], s2};

    generate
        if (SHIFT_CARRY != 0) begin : g_shift
            assign carry_full = {c2, 1'b0};
        end else begin : g_noshift
            assign carry_full = {1'b0, c2};
        end
    endgenerate

    assign sum   = OUTPUT_WIDTH'(sum_full);
    assign carry = OUTPUT_WIDTH'(carry_full);

endmodule

// File: rtl/csa_accumulator_ctrl.sv
// Multi-beat carry-save accumulation controller with a single final carry-propagate add.
// Optional stall counter enabled by defining CSA_ACC_STALL_CNT_EN.
module csa_accumulator_ctrl
    import csa_acc_pkg::*;
#(
    parameter  int INPUT_WIDTH = 14,
    parameter  int ACC_WIDTH   = 16,
    parameter  int MAX_BEATS   = 16,
    localparam int BEAT_W      = $clog2(MAX_BEATS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   clear_i,
    input  logic [BEAT_W-1:0]      num_beats_i,
    input  logic                   is_signed_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [INPUT_WIDTH-1:0] in_data_i [2],
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [ACC_WIDTH-1:0]   result_o,
    output logic                   busy_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_t                 state;
    state_t                 state_nxt;
    logic [ACC_WIDTH-1:0]   sum_q;
    logic [ACC_WIDTH-1:0]   carry_q;
    logic [ACC_WIDTH-1:0]   result_q;
    logic [BEAT_W-1:0]      beat_cnt;
    logic [BEAT_W-1:0]      beat_nxt;
    logic [BEAT_W-1:0]      beats_q;
    logic [BEAT_W-1:0]      beats_in;
    logic                   sgn_q;
    logic                   load;
    logic                   accept;
    logic                   resolve;

    logic [EXT_MAX_W-1:0]   ext0_full;
    logic [EXT_MAX_W-1:0]   ext1_full;
    logic signed [ACC_WIDTH-1:0] op0;
    logic signed [ACC_WIDTH-1:0] op1;
    logic [ACC_WIDTH:0]     cmp_sum;
    logic [ACC_WIDTH:0]     cmp_carry;
    logic                   unused_bits;

    assign ext0_full = ext_operand(EXT_MAX_W'(in_data_i[0]), INPUT_WIDTH, sgn_q);
    assign ext1_full = ext_operand(EXT_MAX_W'(in_data_i[1]), INPUT_WIDTH, sgn_q);
    assign op0       = ext0_full[ACC_WIDTH-1:0];
    assign op1       = ext1_full[ACC_WIDTH-1:0];

    compressor_4_2_n_bit #(
        .INPUT_WIDTH (ACC_WIDTH),
        .OUTPUT_WIDTH(ACC_WIDTH + 1),
        .SHIFT_CARRY (1)
    ) u_cmp (
        .in0  (op0),
        .in1  (op1),
        .in2  (sum_q),
        .in3  (carry_q),
        .sum  (cmp_sum),
        .carry(cmp_carry)
    );

    // Bits above ACC_WIDTH are dropped: the accumulator is modulo 2^ACC_WIDTH.
    assign unused_bits = ^{ext0_full[EXT_MAX_W-1:ACC_WIDTH], ext1_full[EXT_MAX_W-1:ACC_WIDTH],
                           cmp_sum[ACC_WIDTH], cmp_carry[ACC_WIDTH]};

    assign beat_nxt = beat_cnt + 1'b1;
    assign beats_in = (num_beats_i > BEAT_W'(MAX_BEATS)) ? BEAT_W'(MAX_BEATS) : num_beats_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        load        = 1'b0;
        accept      = 1'b0;
        resolve     = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    load      = 1'b1;
                    state_nxt = (num_beats_i == '0) ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    accept = 1'b1;
                    if (beat_nxt == beats_q) begin
                        state_nxt = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                resolve   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort wins over every transition, including a start in IDLE.
        if (clear_i) begin
            state_nxt = IDLE;
            load      = 1'b0;
            accept    = 1'b0;
            resolve   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q    <= '0;
            carry_q  <= '0;
            beat_cnt <= '0;
            beats_q  <= '0;
            sgn_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (clear_i || load) begin
                sum_q    <= '0;
                carry_q  <= '0;
                beat_cnt <= '0;
            end else if (accept) begin
                sum_q    <= cmp_sum[ACC_WIDTH-1:0];
                carry_q  <= cmp_carry[ACC_WIDTH-1:0];
                beat_cnt <= beat_nxt;
            end
            if (load) begin
                beats_q <= beats_in;
                sgn_q   <= is_signed_i;
            end
            if (resolve) begin
                result_q <= sum_q + carry_q;
            end
        end
    end

    assign result_o = result_q;

`ifdef CSA_ACC_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (load) begin
            stall_q <= '0;
        end else if (state == ACCUM && !in_valid_i) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_csa_accumulator_ctrl.sv
// Directed self-checking bench for csa_accumulator_ctrl (INPUT_WIDTH=14, ACC_WIDTH=16).
module tb_csa_accumulator_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic [4:0]  num_beats;
    logic        is_signed;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_data [2];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;
    logic [15:0] stall_cnt;

    int n_run  = 0;
    int n_fail = 0;

    csa_accumulator_ctrl #(
        .INPUT_WIDTH(14),
        .ACC_WIDTH  (16),
        .MAX_BEATS  (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .clear_i    (clear),
        .num_beats_i(num_beats),
        .is_signed_i(is_signed),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .busy_o     (busy),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

`ifdef CSA_ACC_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd4;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [4:0] n, input logic s);
        start     = 1'b1;
        num_beats = n;
        is_signed = s;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [13:0] a, input logic [13:0] b);
        bit taken = 1'b0;
        in_valid   = 1'b1;
        in_data[0] = a;
        in_data[1] = b;
        for (int i = 0; i < 20 && !taken; i++) begin
            if (in_ready) taken = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("handshake", 32'(taken), 32'd1);
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_valid", 32'(out_valid), 32'd0);
        check("consume_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
        num_beats  = '0;
        is_signed  = 1'b0;
        in_valid   = 1'b0;
        in_data[0] = '0;
        in_data[1] = '0;
        out_ready  = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Unsigned 3 beats, exact latency
        start_job(5'd3, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(in_ready), 32'd1);
        send(14'd1, 14'd2);
        send(14'd3, 14'd4);
        send(14'd5, 14'd6);
        check("t1_lat1_valid", 32'(out_valid), 32'd0);
        check("t1_lat1_ready", 32'(in_ready), 32'd0);
        tick();
        check("t1_lat2_valid", 32'(out_valid), 32'd1);
        check("t1_result", 32'(result), 32'h0015);
        consume();

        // Signed and unsigned interpretation of the same data
        start_job(5'd2, 1'b1);
        send(14'h3FFF, 14'h3FFE);
        send(14'h0003, 14'h0000);
        wait_result("t2_signed", 16'h0000);
        consume();
        start_job(5'd2, 1'b0);
        send(14'h3FFF, 14'h3FFE);
        send(14'h0003, 14'h0000);
        wait_result("t2_unsigned", 16'h8000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_clear_valid", 32'(out_valid), 32'd0);
        check("t2_clear_busy", 32'(busy), 32'd0);

        // Wraparound
        start_job(5'd5, 1'b0);
        for (int k = 0; k < 5; k++) send(14'h1FFF, 14'h1FFF);
        wait_result("t3_wrap", 16'h3FF6);
        consume();

        // Input stalls, then output backpressure with an ignored start
        start_job(5'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b0;
            tick();
            send(14'((2 * k + 1) * 10), 14'((2 * k + 2) * 10));
        end
        wait_result("t4_toggle", 16'h0168);
        check("t4_stall", 32'(stall_cnt), EXP_STALL);
        for (int k = 0; k < 5; k++) begin
            start     = 1'b1;
            num_beats = 5'd2;
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_result", 32'(result), 32'h0168);
            check("t4_hold_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        consume();
        check("t4_stall_hold", 32'(stall_cnt), EXP_STALL);

        // Abort mid-job, then a clean follow-up job
        start_job(5'd4, 1'b0);
        send(14'd7, 14'd7);
        send(14'd9, 14'd9);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clear_busy", 32'(busy), 32'd0);
        check("t5_clear_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("t5_no_valid", 32'(out_valid), 32'd0);
        start_job(5'd1, 1'b0);
        check("t5_stall_cleared", 32'(stall_cnt), 32'd0);
        send(14'd1, 14'd1);
        wait_result("t5_fresh", 16'h0002);
        consume();

        // Zero-beat job
        start_job(5'd0, 1'b0);
        check("t6_lat1_valid", 32'(out_valid), 32'd0);
        check("t6_lat1_busy", 32'(busy), 32'd1);
        check("t6_lat1_ready", 32'(in_ready), 32'd0);
        tick();
        check("t6_lat2_valid", 32'(out_valid), 32'd1);
        check("t6_result", 32'(result), 32'h0000);
        consume();

        // start with clear in IDLE
        start     = 1'b1;
        clear     = 1'b1;
        num_beats = 5'd3;
        tick();
        start = 1'b0;
        clear = 1'b0;
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_ready", 32'(in_ready), 32'd0);

        // Beat count above the maximum clamps to 16
        start_job(5'd31, 1'b0);
        for (int k = 0; k < 15; k++) send(14'd1, 14'd0);
        check("t8_still_accum", 32'(in_ready), 32'd1);
        send(14'd1, 14'd0);
        check("t8_resolve", 32'(in_ready), 32'd0);
        wait_result("t8_clamp", 16'h0010);
        consume();

        // Asynchronous reset mid-job
        start_job(5'd2, 1'b0);
        send(14'd5, 14'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t9_busy", 32'(busy), 32'd0);
        check("t9_ready", 32'(in_ready), 32'd0);
        check("t9_valid", 32'(out_valid), 32'd0);
        check("t9_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("t9_after_busy", 32'(busy), 32'd0);
        check("t9_after_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_accumulator_ctrl.md
Name: csa_accumulator_ctrl

Overview:
Sequencing controller for a multi-beat carry-save accumulation. It streams operand pairs into a 4:2 compressor instance, with the registered sum and carry vectors fed back as the third and fourth inputs. After a programmed number of beats, a single carry-propagate add resolves the result. It sits between the partial-product generator and the writeback stage of the AI core MAC datapath.

Parameters:
INPUT_WIDTH, 14, operand width per lane before extension
ACC_WIDTH, 16, accumulator width; all arithmetic is modulo 2^ACC_WIDTH
MAX_BEATS, 16, maximum operand-pair beats per job
BEAT_W, $clog2(MAX_BEATS+1), derived localparam; width of beat fields

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  job start pulse; sampled only in IDLE
clear_i  in  1  synchronous abort; returns to IDLE
num_beats_i  in  BEAT_W  beats in the job, 0..MAX_BEATS
is_signed_i  in  1  operand signedness, latched at start
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  operand pair accepted when high with in_valid_i
in_data_i  in  INPUT_WIDTH x2 (unpacked [2])  operand pair
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed
result_o  out  ACC_WIDTH  resolved accumulation
busy_o  out  1  high in any state except IDLE
stall_cnt_o  out  16  stall counter (optional feature)

Behaviour:
- Reset: state=IDLE, sum_q=carry_q=0, beat_cnt=0, result_q=0. All outputs 0.
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- IDLE:
  - in_ready_o=0, out_valid_o=0.
  - start_i=1 latches num_beats_i and is_signed_i, clears sum_q, carry_q and beat_cnt.
  - Next state is ACCUM, or RESOLVE if num_beats_i=0.
- ACCUM:
  - in_ready_o=1.
  - On handshake: both operands are sign- or zero-extended to ACC_WIDTH per the latched is_signed.
  - The compressor computes {op0, op1, sum_q, carry_q}. Its outputs are truncated to ACC_WIDTH and registered into sum_q and carry_q. beat_cnt increments.
  - A handshake with beat_cnt = latched beats-1 moves to RESOLVE.
  - No handshake: registers hold.
- RESOLVE: result_q <= sum_q + carry_q (mod 2^ACC_WIDTH); next state is DONE. Lasts exactly 1 cycle.
- DONE:
  - out_valid_o=1 and result_o=result_q, held stable until out_ready_i.
  - On out_valid&out_ready, state goes to IDLE.
  - out_valid_o is independent of out_ready_i (no combinational path).
- Latency: out_valid_o rises 2 cycles after the clock edge of the last operand handshake.
- start_i outside IDLE is ignored.
- clear_i has priority over every transition, including start_i in IDLE. It forces IDLE next cycle and zeroes sum_q and carry_q. out_valid_o drops next cycle.
- Overflow wraps silently. No saturation.
- num_beats_i > MAX_BEATS is clamped to MAX_BEATS at latch time.
- Reset assertion mid-job aborts immediately with no pending output.

Optional Feature:
CSA_ACC_STALL_CNT_EN
- Defined: stall_cnt_o counts cycles in ACCUM with in_valid_i=0. It is cleared on accepted start_i, saturates at 0xFFFF, and holds after the job ends.
- Undefined: the counter logic is absent and stall_cnt_o is tied to 0.

Decomposition:
- Shared package csa_acc_pkg:
  - state enum (IDLE, ACCUM, RESOLVE, DONE) as 2-bit logic
  - STALL_CNT_W=16
  - sign-extension function ext_operand(data, is_signed) parameterized by widths
- Sub-module: one instance of compressor_4_2_n_bit with INPUT_WIDTH=ACC_WIDTH, OUTPUT_WIDTH=ACC_WIDTH+1, SHIFT_CARRY=1. Outputs are truncated to ACC_WIDTH.
- FSM, counters and CPA stay in this module.

Test Plan (INPUT_WIDTH=14, ACC_WIDTH=16):
- Unsigned, 3 beats (1,2),(3,4),(5,6) back-to-back -> result_o=21 (0x0015); out_valid_o 2 cycles after the 3rd handshake.
- Signed, 2 beats (0x3FFF,0x3FFE),(0x0003,0x0000) -> 0x0000. Same data unsigned -> 0x8000.
- Unsigned, 5 beats of (0x1FFF,0x1FFF) -> 0x3FF6 (wrap).
- Backpressure:
  - in_valid_i toggled every other cycle during a 4-beat job -> correct sum.
  - out_ready_i low 5 cycles -> result_o/out_valid_o stable, in_ready_o=0, start_i ignored.
  - With CSA_ACC_STALL_CNT_EN, stall_cnt_o equals the stall cycles counted in ACCUM.
- clear_i after 2 of 4 beats -> IDLE next cycle, no out_valid_o. A following job (1,1) -> result 2 (no residue).
- num_beats_i=0 -> result_o=0x0000 with out_valid_o 2 cycles after start. start_i and clear_i together in IDLE -> stays IDLE.
